// File: rtl/pcie2_x1_sync_pulse_mc.sv
// Multi-channel event-pulse synchronizer f_clk -> s_clk over a toggle req/ack handshake, with
// per-channel pending-event counters and sticky overflow. Define PCIE_SYNC_3FF_EN for 3-flop synchronizers.
module pcie2_x1_sync_pulse_mc #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 4
) (
  input  logic             f_clk,
  input  logic             s_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_fclk,
  input  logic [WIDTH-1:0] ovf_clr,
  output logic [WIDTH-1:0] out_sclk,
  output logic [WIDTH-1:0] busy_fclk,
  output logic [WIDTH-1:0] ovf_fclk
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [WIDTH-1:0] req_tog;
  logic [WIDTH-1:0] ack_s1;
  logic [WIDTH-1:0] ack_s2;
  logic [WIDTH-1:0] ack_sync;
  logic [WIDTH-1:0] launch;
  logic [WIDTH-1:0] drop;
  logic [CNT_W-1:0] pend      [WIDTH];
  logic [CNT_W-1:0] pend_next [WIDTH];

  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r3;

  // ---------------- f_clk domain ----------------
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= '0;
      ack_s2 <= '0;
    end else begin
      ack_s1 <= r3;
      ack_s2 <= ack_s1;
    end
  end

`ifdef PCIE_SYNC_3FF_EN
  logic [WIDTH-1:0] ack_s3;

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) ack_s3 <= '0;
    else        ack_s3 <= ack_s2;
  end

  assign ack_sync = ack_s3;
`else
  assign ack_sync = ack_s2;
`endif

  assign busy_fclk = req_tog ^ ack_sync;

  // A full counter with a new event and no launch keeps MAX; the event is lost.
  always_comb begin
    launch = '0;
    drop   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pend_next[i] = pend[i];
      launch[i]    = !busy_fclk[i] && ((pend[i] != '0) || in_fclk[i]);
      drop[i]      = in_fclk[i] && (pend[i] == PEND_MAX) && !launch[i];
      if (in_fclk[i] && !launch[i] && !drop[i])
        pend_next[i] = pend[i] + PEND_ONE;
      else if (!in_fclk[i] && launch[i])
        pend_next[i] = pend[i] - PEND_ONE;
    end
  end

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tog  <= '0;
      ovf_fclk <= '0;
      for (int i = 0; i < WIDTH; i++) pend[i] <= '0;
    end else begin
      req_tog  <= req_tog ^ launch;
      ovf_fclk <= drop | (ovf_fclk & ~ovf_clr);
      for (int i = 0; i < WIDTH; i++) pend[i] <= pend_next[i];
    end
  end

  // ---------------- s_clk domain ----------------
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= req_tog;
      r2 <= r1;
      r3 <= r_last;
    end
  end

`ifdef PCIE_SYNC_3FF_EN
  logic [WIDTH-1:0] r2b;

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) r2b <= '0;
    else        r2b <= r2;
  end

  assign r_last = r2b;
`else
  assign r_last = r2;
`endif

  // r3 doubles as the ack toggle returned to the f_clk side.
  assign out_sclk = r_last ^ r3;

endmodule
